// File: rtl/wr_ptr_full_if.sv
// Write-side bundle of the async FIFO pointer block: producer request, synchronized read
// pointer in, and the write pointer, address, strobe and flags out.
interface wr_ptr_full_if #(
  parameter int unsigned AWIDTH = 3
);
  logic              wrreq_i;
  logic [AWIDTH:0]   rd_pntr_gray_i;
  logic [AWIDTH:0]   wr_pntr_gray_o;
  logic [AWIDTH-1:0] wr_addr_o;
  logic              wr_en_o;
  logic              full_o;
  logic [AWIDTH:0]   usedw_o;
  logic              almost_full_o;

  modport master (
    output wrreq_i, rd_pntr_gray_i,
    input  wr_pntr_gray_o, wr_addr_o, wr_en_o, full_o, usedw_o, almost_full_o
  );

  modport slave (
    input  wrreq_i, rd_pntr_gray_i,
    output wr_pntr_gray_o, wr_addr_o, wr_en_o, full_o, usedw_o, almost_full_o
  );
endinterface

// File: rtl/wr_ptr_full.sv
// Async FIFO write-domain pointer: binary/Gray write pointer, full flag and fill level.
// Define WR_PTR_FULL_ALMOST_FULL_EN to build the registered almost-full flag.
module wr_ptr_full #(
  parameter int unsigned AWIDTH   = 3,
  parameter int unsigned AF_LEVEL = 6
) (
  input logic          clk_i,
  input logic          aclr_i,
  wr_ptr_full_if.slave bus
);

  if (AWIDTH < 2) begin : g_bad_awidth
    $error("AWIDTH must be at least 2");
  end
  if (AF_LEVEL < 1 || AF_LEVEL > (1 << AWIDTH)) begin : g_bad_af_level
    $error("AF_LEVEL must lie in 1..2**AWIDTH");
  end

  logic [AWIDTH:0] r_wbin;
  logic [AWIDTH:0] r_wgray;
  logic            r_full;
  logic [AWIDTH:0] r_usedw;

  logic            w_wr_en;
  logic [AWIDTH:0] w_wbin_next;
  logic [AWIDTH:0] w_wgray_next;
  logic [AWIDTH:0] w_rd_full_cmp;
  logic [AWIDTH:0] w_rbin;
  logic [AWIDTH:0] w_usedw_next;
  logic            w_full_next;

  // Strobe is gated by reset so nothing reaches memory while the pointer is being cleared.
  assign w_wr_en      = bus.wrreq_i & ~r_full & ~aclr_i;
  assign w_wbin_next  = r_wbin + {{AWIDTH{1'b0}}, w_wr_en};
  assign w_wgray_next = w_wbin_next ^ (w_wbin_next >> 1);

  // Full when the write pointer is exactly one lap ahead: top two Gray bits differ.
  assign w_rd_full_cmp = {~bus.rd_pntr_gray_i[AWIDTH:AWIDTH-1], bus.rd_pntr_gray_i[AWIDTH-2:0]};
  assign w_full_next   = (w_wgray_next == w_rd_full_cmp);

  always_comb begin
    w_rbin = '0;
    for (int unsigned i = 0; i <= AWIDTH; i++) begin
      w_rbin[i] = ^(bus.rd_pntr_gray_i >> i);
    end
  end

  assign w_usedw_next = w_wbin_next - w_rbin;

  always_ff @(posedge clk_i or posedge aclr_i) begin
    if (aclr_i) begin
      r_wbin  <= '0;
      r_wgray <= '0;
      r_full  <= 1'b0;
      r_usedw <= '0;
    end else begin
      r_wbin  <= w_wbin_next;
      r_wgray <= w_wgray_next;
      r_full  <= w_full_next;
      r_usedw <= w_usedw_next;
    end
  end

`ifdef WR_PTR_FULL_ALMOST_FULL_EN
  localparam logic [AWIDTH:0] AfLevelW = AF_LEVEL[AWIDTH:0];

  logic r_almost_full;

  always_ff @(posedge clk_i or posedge aclr_i) begin
    if (aclr_i) begin
      r_almost_full <= 1'b0;
    end else begin
      r_almost_full <= (w_usedw_next >= AfLevelW);
    end
  end

  assign bus.almost_full_o = r_almost_full;
`else
  assign bus.almost_full_o = 1'b0;
`endif

  assign bus.wr_en_o        = w_wr_en;
  assign bus.wr_addr_o      = r_wbin[AWIDTH-1:0];
  assign bus.wr_pntr_gray_o = r_wgray;
  assign bus.full_o         = r_full;
  assign bus.usedw_o        = r_usedw;

endmodule

// File: tb/tb_wr_ptr_full.sv
// Self-checking bench for wr_ptr_full (AWIDTH=3, AF_LEVEL=6); a modulo-16 pointer model
// pushes expected outputs to a scoreboard queue that each scenario pops after the edge.
module tb_wr_ptr_full;
  localparam int unsigned AW = 3;

  logic clk;
  logic aclr;

  wr_ptr_full_if #(.AWIDTH(AW)) bus ();

  wr_ptr_full #(
    .AWIDTH  (AW),
    .AF_LEVEL(6)
  ) u_dut (
    .clk_i (clk),
    .aclr_i(aclr),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp;
  int n_fail;

  // Model: binary write/read pointers modulo 16; fill level is their difference.
  int m_wbin;
  int m_rbin;
  int m_used;
  bit m_full;
  bit m_af;

  // Packed {wr_en, addr[2:0], gray[3:0], full, usedw[3:0], almost_full}
  logic [13:0] sb[$];
  logic [13:0] exp_v;
  logic [13:0] act_v;
  logic        obs_wren;

  function automatic logic [3:0] to_gray(input int b);
    logic [3:0] v;
    v = 4'(b);
    return v ^ (v >> 1);
  endfunction

  function automatic logic [13:0] snap(input logic wren);
    return {wren, bus.wr_addr_o, bus.wr_pntr_gray_o, bus.full_o, bus.usedw_o, bus.almost_full_o};
  endfunction

  task automatic model_reset();
    m_wbin = 0;
    m_rbin = 0;
    m_used = 0;
    m_full = 1'b0;
    m_af   = 1'b0;
    sb.delete();
  endtask

  // Drive one cycle of stimulus, record the pre-edge strobe, push the expected post-edge view.
  task automatic step(input logic wrreq, input int rnext, output logic wren_seen);
    logic exp_wren;
    exp_wren = wrreq && !m_full;
    bus.wrreq_i        = wrreq;
    bus.rd_pntr_gray_i = to_gray(rnext);
    #1;
    wren_seen = bus.wr_en_o;
    if (exp_wren) m_wbin = (m_wbin + 1) % 16;
    m_rbin = rnext % 16;
    m_used = (m_wbin - m_rbin + 16) % 16;
    m_full = (m_used == 8);
`ifdef WR_PTR_FULL_ALMOST_FULL_EN
    m_af = (m_used >= 6);
`else
    m_af = 1'b0;
`endif
    sb.push_back({exp_wren, 3'(m_wbin % 8), to_gray(m_wbin), m_full, 4'(m_used), m_af});
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    aclr = 1'b1;
    bus.wrreq_i        = 1'b0;
    bus.rd_pntr_gray_i = '0;
    model_reset();
    @(negedge clk);
    aclr = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    aclr = 1'b1;
    bus.wrreq_i        = 1'b1;
    bus.rd_pntr_gray_i = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    act_v = snap(bus.wr_en_o);
    n_cmp++;
    if (act_v !== 14'h0) begin
      n_fail++;
      $display("FAIL reset_state: got %h expected %h", act_v, 14'h0);
    end
    @(negedge clk);
    aclr = 1'b0;
    bus.wrreq_i = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_fill();
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (bus.wr_addr_o !== 3'(i)) begin
        n_fail++;
        $display("FAIL fill_addr[%0d]: got %0d expected %0d", i, bus.wr_addr_o, i);
      end
      step(1'b1, 0, obs_wren);
      exp_v = sb.pop_front();
      act_v = snap(obs_wren);
      n_cmp++;
      if (act_v !== exp_v) begin
        n_fail++;
        $display("FAIL fill[%0d]: got %h expected %h", i, act_v, exp_v);
      end
    end
    n_cmp++;
    if ({bus.full_o, bus.usedw_o, bus.wr_pntr_gray_o} !== {1'b1, 4'd8, 4'b1100}) begin
      n_fail++;
      $display("FAIL fill_final: got full=%b usedw=%0d gray=%b expected 1/8/1100",
               bus.full_o, bus.usedw_o, bus.wr_pntr_gray_o);
    end
  endtask

  task automatic test_full_ignore();
    step(1'b1, 0, obs_wren);
    exp_v = sb.pop_front();
    act_v = snap(obs_wren);
    n_cmp++;
    if (act_v !== exp_v) begin
      n_fail++;
      $display("FAIL full_ignore: got %h expected %h", act_v, exp_v);
    end
    n_cmp++;
    if ({obs_wren, bus.wr_pntr_gray_o, bus.usedw_o} !== {1'b0, 4'b1100, 4'd8}) begin
      n_fail++;
      $display("FAIL full_ignore_hold: got wr_en=%b gray=%b usedw=%0d expected 0/1100/8",
               obs_wren, bus.wr_pntr_gray_o, bus.usedw_o);
    end
  endtask

  task automatic test_read_release();
    // Read advance alone, write refill, read again, then simultaneous write and read.
    int rseq[4] = '{1, 1, 2, 3};
    bit wseq[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      step(wseq[i], rseq[i], obs_wren);
      exp_v = sb.pop_front();
      act_v = snap(obs_wren);
      n_cmp++;
      if (act_v !== exp_v) begin
        n_fail++;
        $display("FAIL read_release[%0d]: got %h expected %h", i, act_v, exp_v);
      end
      if (i == 0) begin
        n_cmp++;
        if ({bus.full_o, bus.usedw_o} !== {1'b0, 4'd7}) begin
          n_fail++;
          $display("FAIL release_clear: got full=%b usedw=%0d expected 0/7",
                   bus.full_o, bus.usedw_o);
        end
      end else if (i == 1) begin
        n_cmp++;
        if ({bus.full_o, bus.usedw_o} !== {1'b1, 4'd8}) begin
          n_fail++;
          $display("FAIL release_refill: got full=%b usedw=%0d expected 1/8",
                   bus.full_o, bus.usedw_o);
        end
      end
    end
  endtask

  task automatic test_wrap();
    logic [3:0] prev_gray;
    bit         seen_wrap;
    bit         bad_steady;
    do_reset();
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 0, obs_wren);
      void'(sb.pop_front());
    end
    seen_wrap  = 1'b0;
    bad_steady = 1'b0;
    for (int i = 0; i < 20; i++) begin
      prev_gray = bus.wr_pntr_gray_o;
      step(1'b1, (m_wbin + 16 - 1) % 16, obs_wren);
      exp_v = sb.pop_front();
      act_v = snap(obs_wren);
      n_cmp++;
      if (act_v !== exp_v) begin
        n_fail++;
        $display("FAIL wrap[%0d]: got %h expected %h", i, act_v, exp_v);
      end
      if (bus.full_o !== 1'b0 || bus.usedw_o !== 4'd2) bad_steady = 1'b1;
      if (prev_gray === 4'b1000 && bus.wr_pntr_gray_o === 4'b0000) seen_wrap = 1'b1;
    end
    n_cmp++;
    if (bad_steady || !seen_wrap) begin
      n_fail++;
      $display("FAIL wrap_summary: got steady_bad=%b wrap_seen=%b expected 0/1",
               bad_steady, seen_wrap);
    end
  endtask

  task automatic test_midclock_reset();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 0, obs_wren);
      void'(sb.pop_front());
    end
    bus.wrreq_i = 1'b1;
    #2;
    aclr = 1'b1;
    #1;
    act_v = snap(bus.wr_en_o);
    n_cmp++;
    if (act_v !== 14'h0) begin
      n_fail++;
      $display("FAIL midclock_reset: got %h expected %h", act_v, 14'h0);
    end
    model_reset();
    @(negedge clk);
    aclr = 1'b0;
    bus.wrreq_i = 1'b0;
    @(posedge clk);
    #1;
    n_cmp++;
    if (bus.wr_addr_o !== 3'd0) begin
      n_fail++;
      $display("FAIL post_reset_addr: got %0d expected 0", bus.wr_addr_o);
    end
    step(1'b1, 0, obs_wren);
    exp_v = sb.pop_front();
    act_v = snap(obs_wren);
    n_cmp++;
    if (act_v !== exp_v) begin
      n_fail++;
      $display("FAIL post_reset_write: got %h expected %h", act_v, exp_v);
    end
  endtask

  task automatic test_almost_full();
    logic exp_af6;
`ifdef WR_PTR_FULL_ALMOST_FULL_EN
    exp_af6 = 1'b1;
`else
    exp_af6 = 1'b0;
`endif
    do_reset();
    for (int i = 1; i <= 6; i++) begin
      step(1'b1, 0, obs_wren);
      exp_v = sb.pop_front();
      act_v = snap(obs_wren);
      n_cmp++;
      if (act_v !== exp_v) begin
        n_fail++;
        $display("FAIL almost_full[%0d]: got %h expected %h", i, act_v, exp_v);
      end
      if (i == 5) begin
        n_cmp++;
        if (bus.almost_full_o !== 1'b0) begin
          n_fail++;
          $display("FAIL af_after5: got %b expected 0", bus.almost_full_o);
        end
      end else if (i == 6) begin
        n_cmp++;
        if (bus.almost_full_o !== exp_af6) begin
          n_fail++;
          $display("FAIL af_after6: got %b expected %b", bus.almost_full_o, exp_af6);
        end
      end
    end
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    aclr   = 1'b1;
    bus.wrreq_i        = 1'b0;
    bus.rd_pntr_gray_i = '0;
    test_reset();
    test_fill();
    test_full_ignore();
    test_read_release();
    test_wrap();
    test_midclock_reset();
    test_almost_full();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
